// File: rtl/fsm_arb_pkg.sv
// rtl/fsm_arb_pkg.sv - shared types and widths for the FSM session arbiter
package fsm_arb_pkg;

  localparam int SYM_W = 2;
  localparam int Y_W   = 5;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting at ptr_i
module rr_pick
  import fsm_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  idx_o
);

  logic found;
  int   j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr_i) + i) % N_REQ;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/fsm_session_arbiter.sv
// rtl/fsm_session_arbiter.sv - grants exclusive, freshly cleared FSM sessions to requesters
module fsm_session_arbiter
  import fsm_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       valid,
  input  logic [N_REQ-1:0]       last,
  input  logic [SYM_W*N_REQ-1:0] sym,
  output logic [N_REQ-1:0]       grant,
  output logic                   accept,
  output logic                   fsm_reset_n,
  output logic                   fsm_enable,
  output logic [SYM_W-1:0]       fsm_a,
  input  logic [Y_W-1:0]         fsm_y,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [Y_W-1:0]         rsp_y,
  output logic                   abort
);

  localparam logic [8:0] MAX_B9 = 9'(MAX_BURST);
  localparam logic [8:0] TMO_9  = 9'(TIMEOUT);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]   owner_oh_q, owner_oh_d;
  logic [7:0]         burst_q, burst_d, idle_q, idle_d;
  logic               fsm_rst_n_q, fsm_rst_n_d;
  logic               acc1_q;
  logic [ID_W-1:0]    id1_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [Y_W-1:0]     rsp_y_q;

  logic [N_REQ-1:0]   pick_oh;
  logic [ID_W-1:0]    pick_idx;
  logic               own_req, own_valid, own_last, end_session;
  logic [SYM_W-1:0]   own_sym;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_oh),
    .idx_o   (pick_idx)
  );

  always_comb begin
    own_req   = 1'b0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_sym   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == ID_W'(i)) begin
        own_req   = req[i];
        own_valid = valid[i];
        own_last  = last[i];
        own_sym   = sym[SYM_W*i +: SYM_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    owner_oh_d  = owner_oh_q;
    rr_ptr_d    = rr_ptr_q;
    burst_d     = burst_q;
    idle_d      = idle_q;
    grant       = '0;
    accept      = 1'b0;
    fsm_enable  = 1'b0;
    fsm_a       = '0;
    abort       = 1'b0;
    end_session = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d    = pick_idx;
          owner_oh_d = pick_oh;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        grant   = owner_oh_q;
        burst_d = '0;
        idle_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        grant      = owner_oh_q;
        accept     = own_valid;
        fsm_enable = own_valid;
        fsm_a      = own_valid ? own_sym : '0;
        if (own_valid) begin
          burst_d = burst_q + 8'd1;
          idle_d  = '0;
          if (own_last || !own_req || ({1'b0, burst_q} + 9'd1 == MAX_B9))
            end_session = 1'b1;
        end else if (!own_req) begin
          end_session = 1'b1;
        end else begin
          idle_d = idle_q + 8'd1;
          if ({1'b0, idle_q} + 9'd1 == TMO_9) begin
            abort       = 1'b1;
            end_session = 1'b1;
          end
        end
        if (end_session) begin
          state_d  = IDLE;
          rr_ptr_d = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + ID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Flop the FSM reset so it is low exactly while CLEAR is the current state.
    fsm_rst_n_d = (state_d != CLEAR);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      owner_oh_q  <= '0;
      rr_ptr_q    <= '0;
      burst_q     <= '0;
      idle_q      <= '0;
      fsm_rst_n_q <= 1'b0;
      acc1_q      <= 1'b0;
      id1_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      owner_oh_q  <= owner_oh_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_q     <= burst_d;
      idle_q      <= idle_d;
      fsm_rst_n_q <= fsm_rst_n_d;
      acc1_q      <= accept;
      id1_q       <= owner_q;
      rsp_valid_q <= acc1_q;
      if (acc1_q) begin
        rsp_id_q <= id1_q;
        rsp_y_q  <= fsm_y;
      end
    end
  end

  assign fsm_reset_n = fsm_rst_n_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_y       = rsp_y_q;

endmodule

// File: doc/fsm_session_arbiter.md
# fsm_session_arbiter

Shares one 2-bit-symbol control FSM (clock/reset_n/enable/a in, y[4:0] out) between `N_REQ` requesters. A winner gets an exclusive session: the arbiter clears the FSM, forwards that requester's symbols as enable/a strobes, and returns each resulting y vector tagged with the requester id. Sessions give each requester a clean, uninterleaved FSM history. The block sits between the requester logic and the FSM instance.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `MAX_BURST`, 8: maximum symbols accepted per session (1..255).
- `TIMEOUT`, 16: idle cycles an owner may stall before its session is aborted (1..255).
- `clock` in 1: single clock, all logic on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req` in N_REQ: requester i wants, or holds, a session.
- `valid` in N_REQ: requester i presents a symbol.
- `last` in N_REQ: presented symbol closes the session.
- `sym` in 2*N_REQ: symbol of requester i at bits [2i+1:2i].
- `grant` out N_REQ: one-hot current owner; 0 when no session is active.
- `accept` out 1: the owner's symbol is consumed this cycle.
- `fsm_reset_n` out 1: registered reset to the FSM.
- `fsm_enable` out 1: FSM enable.
- `fsm_a` out 2: FSM symbol input.
- `fsm_y` in 5: FSM registered outputs.
- `rsp_valid` out 1: response strobe.
- `rsp_id` out 3: requester index of the response.
- `rsp_y` out 5: FSM outputs after the symbol.
- `abort` out 1: one-cycle pulse when a session ends by timeout.

## Operation
- States: IDLE, CLEAR, RUN.
- **IDLE**: `grant` is 0. If any `req` is high, the round-robin pick starts at `rr_ptr`. The winner is latched as owner and the state goes to CLEAR. With no `req`, the block stays in IDLE.
- **CLEAR**: exactly one cycle.
  - `fsm_reset_n` is 0 and `grant` is the owner.
  - Clears the burst counter and the idle counter.
  - Next state is RUN.
- **RUN**:
  - `accept = fsm_enable = valid[owner]` (combinational).
  - `fsm_a = sym[owner]` when enabled, else 2'b00.
  - Each accept increments the burst count and clears the idle counter.
  - Each cycle without an accept increments the idle counter.
- A session ends (next state IDLE, `rr_ptr` = owner+1 mod N_REQ) on the first of these:
  - An accepted symbol with `last[owner]`.
  - The accepted symbol that brings the burst count to `MAX_BURST`.
  - `req[owner]` low while `valid[owner]` is low. No issue occurs that cycle.
  - Idle counter reaches `TIMEOUT`. `abort` pulses that cycle.
- If `req[owner]` is low while `valid[owner]` is high, the symbol is still accepted and the session then ends.
- **Response path**:
  - The issue cycle is the cycle in which `accept` is high (cycle N).
  - `rsp_valid` is high in cycle N+2, with `rsp_id` = owner and `rsp_y` = the `fsm_y` value sampled in cycle N+1.
  - Back-to-back accepts give back-to-back responses.
- `valid`/`sym`/`last` of non-owners are ignored. `req` changes outside IDLE do not affect the current session.
- **Reset** (`reset_n` low at an edge), including mid-session:
  - State IDLE, `rr_ptr` 0.
  - `grant` 0, `accept` 0, `fsm_enable` 0, `fsm_a` 0.
  - `fsm_reset_n` 0, then 1 from the first cycle after release.
  - `rsp_valid` 0, `rsp_id` 0, `rsp_y` 0, `abort` 0.
  - Any in-flight response is dropped.

## Timing
- Request to first possible accept: 2 cycles (IDLE pick, CLEAR).
- A session ending on an accept in cycle N returns to IDLE in N+1. CLEAR is therefore no earlier than N+2, so `fsm_reset_n` is never low in the capture cycle N+1. This guarantees the final response is not zeroed by the FSM's asynchronous reset.
- `fsm_reset_n` is driven directly from a flop and is glitch-free.
- `fsm_enable`/`fsm_a`/`accept` depend combinationally on `valid`/`sym` within RUN only.
- Idle counter and burst counter are 8 bits, compared against the parameters with no wrap.

## Structure
- Package `fsm_arb_pkg`:
  - State enum: IDLE, CLEAR, RUN.
  - `SYM_W`=2, `Y_W`=5, `ID_W`=3.
- Sub-module `rr_pick`:
  - Inputs: N_REQ request vector and pointer.
  - Outputs: one-hot winner and binary index.
  - Combinational.

## Test plan
- Single session: req[2] holds, three valid symbols 00,01,10, the last with `last`.
  - `fsm_reset_n` is low for 1 cycle.
  - Three `accept`s, then three `rsp_valid` with `rsp_id`=2, each 2 cycles after its accept.
  - `grant` is 0 the cycle after the last accept.
- Fairness: `req`=4'b1111 constant, each session a single `last` symbol.
  - Grants rotate 0→1→2→3→0.
- Burst limit: owner streams 10 symbols with no `last`, MAX_BURST=8.
  - Exactly 8 accepts, then IDLE; a new CLEAR is granted to the next requester.
- Timeout: owner holds `req` with `valid` low for 16 cycles.
  - `abort` pulses once and `grant` drops; no response is produced.
- Reset mid-session: assert `reset_n` low one cycle after an accept.
  - No `rsp_valid`.
  - All outputs take their reset values, with `fsm_reset_n`=0 during reset.
  - After release, the next grant goes to requester 0 (`rr_ptr`=0).
